ex_stage: RTL

Execute stage of the five-stage MIPS pipeline: the consumer end of the ID-to-EX bus and the producer of the EX-to-ID forwarding bus. It latches the decoded bundle, selects operands, runs the 12-way ALU and drives the data-SRAM request. It also holds the HI/LO registers and an iterative 32-cycle divider that stalls the pipeline through `stallreq`.

---
 rtl/ex_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with operand select, 12-way ALU, HI/LO and data-SRAM request.
// Define EX_DIV_EN to build in the iterative 32-cycle div/divu unit that drives stallreq.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [37:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq
);
    logic [158:0] r_bus;
    logic [31:0]  r_hi, r_lo;
    logic [31:0]  w_pc, w_inst, w_rdata1, w_rdata2;
    logic [31:0]  w_src1, w_src2, w_imm_sext, w_imm_zext;
    logic [31:0]  w_alu_res, w_sra, w_ex_result;
    logic [11:0]  w_alu_op;
    logic [2:0]   w_sel1;
    logic [3:0]   w_sel2, w_ram_wen;
    logic         w_ram_en, w_rf_we, w_sel_rf_res;
    logic [4:0]   w_rf_waddr;
    logic [5:0]   w_func;
    logic         w_special, w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic         w_div_wr;
    logic [31:0]  w_div_hi, w_div_lo;
    logic         w_unused;

    // stall[2] with stall[3] released means MEM moves on while EX must not: inject a bubble.
    always_ff @(posedge clk) begin
        if (!rst)                       r_bus <= '0;
        else if (stall[2] && !stall[3]) r_bus <= '0;
        else if (!stall[2])             r_bus <= id_to_ex_bus;
    end

    assign {w_pc, w_inst, w_alu_op, w_sel1, w_sel2, w_ram_en, w_ram_wen,
            w_rf_we, w_rf_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_bus;

    assign w_func    = w_inst[5:0];
    assign w_special = (w_inst[31:26] == 6'b0);
    assign w_mfhi    = w_special && (w_func == 6'h10);
    assign w_mthi    = w_special && (w_func == 6'h11);
    assign w_mflo    = w_special && (w_func == 6'h12);
    assign w_mtlo    = w_special && (w_func == 6'h13);

    assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
    assign w_imm_zext = {16'b0, w_inst[15:0]};
    assign w_src1 = w_sel1[1] ? w_pc :
                    w_sel1[2] ? {27'b0, w_inst[10:6]} : w_rdata1;
    assign w_src2 = w_sel2[1] ? w_imm_sext :
                    w_sel2[2] ? 32'd8 :
                    w_sel2[3] ? w_imm_zext : w_rdata2;

    // Kept as its own net so the arithmetic shift is not demoted to unsigned by the AND-OR below.
    assign w_sra = $signed(w_src2) >>> w_src1[4:0];

    assign w_alu_res =
          ({32{w_alu_op[11]}} & (w_src1 + w_src2))
        | ({32{w_alu_op[10]}} & (w_src1 - w_src2))
        | ({32{w_alu_op[9]}}  & {31'b0, $signed(w_src1) < $signed(w_src2)})
        | ({32{w_alu_op[8]}}  & {31'b0, w_src1 < w_src2})
        | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
        | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
        | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
        | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
        | ({32{w_alu_op[3]}}  & (w_src2 << w_src1[4:0]))
        | ({32{w_alu_op[2]}}  & (w_src2 >> w_src1[4:0]))
        | ({32{w_alu_op[1]}}  & w_sra)
        | ({32{w_alu_op[0]}}  & {w_src2[15:0], 16'b0});

    assign w_ex_result = w_mfhi ? r_hi : (w_mflo ? r_lo : w_alu_res);

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_quot, r_rem, r_divisor, r_dividend_raw;
    logic        r_neg_q, r_neg_r, r_by_zero;
    logic        w_div_any, w_div_signed;
    logic [32:0] w_rem_shift, w_diff;

    assign w_div_signed = w_special && (w_func == 6'h1A);
    assign w_div_any    = w_div_signed || (w_special && (w_func == 6'h1B));
    assign w_rem_shift  = {r_rem, r_quot[31]};
    assign w_diff       = w_rem_shift - {1'b0, r_divisor};

    // Restoring division on magnitudes; the dividend shifts out of r_quot as quotient bits shift in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_quot         <= '0;
            r_rem          <= '0;
            r_divisor      <= '0;
            r_dividend_raw <= '0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_by_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_div_any) begin
                        r_quot         <= (w_div_signed && w_rdata1[31]) ? -w_rdata1 : w_rdata1;
                        r_divisor      <= (w_div_signed && w_rdata2[31]) ? -w_rdata2 : w_rdata2;
                        r_dividend_raw <= w_rdata1;
                        r_rem          <= '0;
                        r_cnt          <= '0;
                        r_neg_q        <= w_div_signed && (w_rdata1[31] ^ w_rdata2[31]);
                        r_neg_r        <= w_div_signed && w_rdata1[31];
                        r_by_zero      <= (w_rdata2 == 32'b0);
                        r_state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_rem  <= w_diff[32] ? w_rem_shift[31:0] : w_diff[31:0];
                    r_quot <= {r_quot[30:0], ~w_diff[32]};
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_div_wr = (r_state == S_DONE);
    assign w_div_lo = r_by_zero ? 32'hFFFF_FFFF : (r_neg_q ? -r_quot : r_quot);
    assign w_div_hi = r_by_zero ? r_dividend_raw : (r_neg_r ? -r_rem : r_rem);
    assign stallreq = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_div_any);
`else
    assign w_div_wr = 1'b0;
    assign w_div_lo = '0;
    assign w_div_hi = '0;
    assign stallreq = 1'b0;
`endif

    // A finishing divide wins over mthi/mtlo; those only commit when MEM accepts the instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_wr) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
        end else if (!stall[3]) begin
            if (w_mthi) r_hi <= w_rdata1;
            if (w_mtlo) r_lo <= w_rdata1;
        end
    end

    assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_ex_result};
    assign ex_to_id_bus    = {w_rf_we, w_rf_waddr, w_ex_result};
    assign data_sram_en    = w_ram_en;
    assign data_sram_wen   = w_ram_wen;
    assign data_sram_addr  = w_ex_result;
    assign data_sram_wdata = w_rdata2;

    assign w_unused = ^{stall[5:4], stall[1:0], w_inst[25:16], w_sel1[0], w_sel2[0]};
endmodule
